// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
// Holds the arbiter state encoding and the default port widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } arb_state_t;

  localparam int N_DEF       = 64;
  localparam int STALL_W_DEF = 32;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter used for the stall statistics.
// Ports: clk, reset (sync, active-high), en (count), q (count value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Ports: clk/reset, fetch side (if_*), data side (dm_*), memory side
// (mem_*), pipeline stalls (stall_F, stall_M), stall_cnt, err_rw.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int STALL_W = STALL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [N-1:0]       if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ack,
  input  logic               dm_read,
  input  logic               dm_write,
  input  logic [N-1:0]       dm_addr,
  input  logic [N-1:0]       dm_wdata,
  output logic [N-1:0]       dm_rdata,
  output logic               dm_ack,
  output logic               mem_valid,
  output logic               mem_we,
  output logic [N-1:0]       mem_addr,
  output logic [N-1:0]       mem_wdata,
  input  logic [N-1:0]       mem_rdata,
  input  logic               mem_ready,
  output logic               stall_F,
  output logic               stall_M,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               err_rw
);

  arb_state_t   state;
  arb_state_t   next;
  logic         dm_req;
  logic         we_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;

  assign dm_req = dm_read | dm_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        // Data wins over fetch; mem_ready is ignored here.
        if (dm_req) begin
          next = DATA;
        end else if (if_req) begin
          next = INST;
        end
      end
      DATA, INST: begin
        if (mem_ready) begin
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  // Request is captured only when leaving IDLE and held until the
  // next capture, so a requester changing its inputs mid-wait is
  // invisible to memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_rw  <= 1'b0;
    end else if (state == IDLE) begin
      if (dm_req) begin
        // A read+write collision degenerates into a write.
        we_q    <= dm_write;
        addr_q  <= dm_addr;
        wdata_q <= dm_wdata;
        if (dm_read && dm_write) begin
          err_rw <= 1'b1;
        end
      end else if (if_req) begin
        we_q    <= 1'b0;
        addr_q  <= if_addr;
        wdata_q <= '0;
      end
    end
  end

  assign mem_valid = (state == DATA) || (state == INST);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign dm_ack   = (state == DATA) && mem_ready;
  assign if_ack   = (state == INST) && mem_ready;
  assign dm_rdata = mem_rdata;
  assign if_rdata = mem_rdata[31:0];

  assign stall_F = if_req & ~if_ack;
  assign stall_M = dm_req & ~dm_ack;

  sat_counter #(
    .W(STALL_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (stall_F | stall_M),
    .q    (stall_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction scoreboard.
// A second instance with a 3-bit stall counter covers saturation.
module tb_mem_arbiter;

  localparam int N = 64;

  typedef struct {
    logic         is_data;
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req;
  logic [N-1:0] if_addr;
  logic [31:0]  if_rdata;
  logic         if_ack;
  logic         dm_read;
  logic         dm_write;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic [N-1:0] dm_rdata;
  logic         dm_ack;
  logic         mem_valid;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;
  logic         stall_F;
  logic         stall_M;
  logic [31:0]  stall_cnt;
  logic         err_rw;

  logic         if_req3;
  logic         mem_ready3;
  logic [N-1:0] zero_n;
  logic         zero_1;
  logic [31:0]  if_rdata3;
  logic         if_ack3;
  logic [N-1:0] dm_rdata3;
  logic         dm_ack3;
  logic         mem_valid3;
  logic         mem_we3;
  logic [N-1:0] mem_addr3;
  logic [N-1:0] mem_wdata3;
  logic         stall_F3;
  logic         stall_M3;
  logic [2:0]   stall_cnt3;
  logic         err_rw3;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.N(N), .STALL_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_F  (stall_F),
    .stall_M  (stall_M),
    .stall_cnt(stall_cnt),
    .err_rw   (err_rw)
  );

  mem_arbiter #(.N(N), .STALL_W(3)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req3),
    .if_addr  (zero_n),
    .if_rdata (if_rdata3),
    .if_ack   (if_ack3),
    .dm_read  (zero_1),
    .dm_write (zero_1),
    .dm_addr  (zero_n),
    .dm_wdata (zero_n),
    .dm_rdata (dm_rdata3),
    .dm_ack   (dm_ack3),
    .mem_valid(mem_valid3),
    .mem_we   (mem_we3),
    .mem_addr (mem_addr3),
    .mem_wdata(mem_wdata3),
    .mem_rdata(zero_n),
    .mem_ready(mem_ready3),
    .stall_F  (stall_F3),
    .stall_M  (stall_M3),
    .stall_cnt(stall_cnt3),
    .err_rw   (err_rw3)
  );

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every ack is matched against the oldest expected transaction.
  always @(negedge clk) begin
    if (dm_ack === 1'b1 || if_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_ack: dm_ack=%0b if_ack=%0b, none expected",
                 dm_ack, if_ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_dm_ack", {63'd0, dm_ack}, {63'd0, e.is_data});
        check("sb_if_ack", {63'd0, if_ack}, {63'd0, ~e.is_data});
        check("sb_addr", mem_addr, e.addr);
        check("sb_we", {63'd0, mem_we}, {63'd0, e.we});
        check("sb_wdata", mem_wdata, e.wdata);
        if (e.is_data) check("sb_dm_rdata", dm_rdata, e.rdata);
        else check("sb_if_rdata", {32'd0, if_rdata}, e.rdata);
      end
    end
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    if_req = 0; if_addr = '0;
    dm_read = 0; dm_write = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    if_req3 = 0; mem_ready3 = 0; zero_n = '0; zero_1 = 0;
    step(); step();
    reset = 1'b0;
    sample();
    check("rst_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_we", {63'd0, mem_we}, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_cnt", {32'd0, stall_cnt}, 64'd0);
    check("rst_err", {63'd0, err_rw}, 64'd0);

    // Fetch only, ready one cycle after valid.
    step();
    if_req = 1; if_addr = 64'h40; mem_rdata = 64'hF800_0000;
    e = '{1'b0, 1'b0, 64'h40, 64'h0, 64'hF800_0000};
    exp_q.push_back(e);
    sample();
    check("f_stallF0", {63'd0, stall_F}, 64'd1);
    check("f_valid0", {63'd0, mem_valid}, 64'd0);
    step();
    sample();
    check("f_valid1", {63'd0, mem_valid}, 64'd1);
    check("f_we1", {63'd0, mem_we}, 64'd0);
    check("f_stallF1", {63'd0, stall_F}, 64'd1);
    check("f_ack1", {63'd0, if_ack}, 64'd0);
    step();
    mem_ready = 1;
    sample();
    check("f_valid2", {63'd0, mem_valid}, 64'd1);
    check("f_ack2", {63'd0, if_ack}, 64'd1);
    check("f_stallF2", {63'd0, stall_F}, 64'd0);
    step();
    if_req = 0; mem_ready = 0;
    sample();
    check("f_valid3", {63'd0, mem_valid}, 64'd0);
    check("f_cnt", {32'd0, stall_cnt}, 64'd2);

    // Simultaneous data read and fetch; ready high already in IDLE.
    step();
    if_req = 1; if_addr = 64'h44;
    dm_read = 1; dm_addr = 64'h100;
    mem_rdata = 64'h1234_5678_9ABC_DEF0; mem_ready = 1;
    e = '{1'b1, 1'b0, 64'h100, 64'h0, 64'h1234_5678_9ABC_DEF0};
    exp_q.push_back(e);
    e = '{1'b0, 1'b0, 64'h44, 64'h0, 64'h9ABC_DEF0};
    exp_q.push_back(e);
    sample();
    check("p_idle_valid", {63'd0, mem_valid}, 64'd0);
    check("p_idle_dmack", {63'd0, dm_ack}, 64'd0);
    check("p_stallF0", {63'd0, stall_F}, 64'd1);
    check("p_stallM0", {63'd0, stall_M}, 64'd1);
    step();
    sample();
    check("p_data_addr", mem_addr, 64'h100);
    check("p_stallF1", {63'd0, stall_F}, 64'd1);
    check("p_stallM1", {63'd0, stall_M}, 64'd0);
    step();
    dm_read = 0;
    sample();
    check("p_gap_valid", {63'd0, mem_valid}, 64'd0);
    check("p_stallF2", {63'd0, stall_F}, 64'd1);
    step();
    sample();
    check("p_inst_addr", mem_addr, 64'h44);
    check("p_inst_valid", {63'd0, mem_valid}, 64'd1);
    step();
    if_req = 0; mem_ready = 0;
    sample();
    check("p_cnt", {32'd0, stall_cnt}, 64'd5);

    // Store with address changed during the wait.
    step();
    dm_write = 1; dm_addr = 64'h8; dm_wdata = 64'hA5;
    mem_rdata = 64'h0;
    e = '{1'b1, 1'b1, 64'h8, 64'hA5, 64'h0};
    exp_q.push_back(e);
    sample();
    step();
    dm_addr = 64'h10;
    sample();
    check("s_we", {63'd0, mem_we}, 64'd1);
    check("s_addr1", mem_addr, 64'h8);
    check("s_wdata1", mem_wdata, 64'hA5);
    step();
    sample();
    check("s_addr2", mem_addr, 64'h8);
    check("s_ack2", {63'd0, dm_ack}, 64'd0);
    step();
    mem_ready = 1;
    sample();
    check("s_ack3", {63'd0, dm_ack}, 64'd1);
    step();
    dm_write = 0; mem_ready = 0;
    sample();
    check("s_ack4", {63'd0, dm_ack}, 64'd0);
    check("s_valid4", {63'd0, mem_valid}, 64'd0);

    // Read and write together: treated as a write, err_rw sticks.
    step();
    dm_read = 1; dm_write = 1; dm_addr = 64'h20; dm_wdata = 64'h55;
    mem_ready = 1;
    e = '{1'b1, 1'b1, 64'h20, 64'h55, 64'h0};
    exp_q.push_back(e);
    sample();
    check("rw_err0", {63'd0, err_rw}, 64'd0);
    step();
    sample();
    check("rw_we", {63'd0, mem_we}, 64'd1);
    check("rw_err1", {63'd0, err_rw}, 64'd1);
    step();
    dm_read = 0; dm_write = 0; mem_ready = 0;
    step(); step();
    sample();
    check("rw_err_sticky", {63'd0, err_rw}, 64'd1);

    // Reset in the middle of a data read.
    step();
    dm_read = 1; dm_addr = 64'h30;
    sample();
    step();
    sample();
    check("r_valid_before", {63'd0, mem_valid}, 64'd1);
    reset = 1;
    step();
    mem_ready = 1;
    sample();
    check("r_valid", {63'd0, mem_valid}, 64'd0);
    check("r_dmack", {63'd0, dm_ack}, 64'd0);
    check("r_cnt", {32'd0, stall_cnt}, 64'd0);
    check("r_err", {63'd0, err_rw}, 64'd0);
    check("r_addr", mem_addr, 64'd0);
    step();
    reset = 0; dm_read = 0; mem_ready = 0;
    sample();
    check("r_idle_valid", {63'd0, mem_valid}, 64'd0);

    // 3-bit counter saturation.
    step();
    if_req3 = 1;
    for (int i = 0; i < 5; i++) step();
    sample();
    check("sat_cnt5", {61'd0, stall_cnt3}, 64'd5);
    for (int i = 0; i < 5; i++) step();
    sample();
    check("sat_cnt10", {61'd0, stall_cnt3}, 64'd7);
    step(); step();
    sample();
    check("sat_cnt12", {61'd0, stall_cnt3}, 64'd7);
    if_req3 = 0;

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
